// File: rtl/vga_arb_pkg.sv
// rtl/vga_arb_pkg.sv - shared widths and write-request record for the VGA RAM arbiter
package vga_arb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/vga_ram_arbiter_if.sv
// rtl/vga_ram_arbiter_if.sv - valid/ready pixel writer bus into the VGA RAM arbiter
interface vga_ram_arbiter_if;
  import vga_arb_pkg::*;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/vga_wr_fifo.sv
// rtl/vga_wr_fifo.sv - small synchronous FIFO buffering pixel writes until a free RAM slot
module vga_wr_fifo
  import vga_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wr_req_t          push_req,
  input  logic             pop,
  output wr_req_t          head,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  wr_req_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Entry storage needs no reset: level/pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_req;
  end

  // Pointers wrap naturally (power-of-2 depth); level tracks occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (!do_push && do_pop) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/vga_ram_arbiter.sv
// rtl/vga_ram_arbiter.sv - shares the image RAM between VGA scan-out reads and a buffered writer; VGA_ARB_STARVE_GUARD_EN adds slot stealing
module vga_ram_arbiter
  import vga_arb_pkg::wr_req_t;
#(
  parameter int ADDR_W        = vga_arb_pkg::ADDR_W,
  parameter int DATA_W        = vga_arb_pkg::DATA_W,
  parameter int WR_FIFO_DEPTH = 4,
  parameter int MAX_WAIT      = 16,
  localparam int LVL_W = $clog2(WR_FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_data,
  output logic              vga_stall,
  vga_ram_arbiter_if.slave  wr_bus,
  output logic [LVL_W-1:0]  fifo_level,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  if (WR_FIFO_DEPTH < 2 || (WR_FIFO_DEPTH & (WR_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("WR_FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (MAX_WAIT < 1) begin : g_bad_wait
    $error("MAX_WAIT must be at least 1");
  end
  if (ADDR_W != vga_arb_pkg::ADDR_W || DATA_W != vga_arb_pkg::DATA_W) begin : g_bad_width
    $error("ADDR_W/DATA_W must match vga_arb_pkg");
  end

  wr_req_t push_req;
  wr_req_t head;
  logic    full;
  logic    empty;
  logic    push;
  logic    pop;
  logic    steal;
  logic    ready_q;

  assign push_req.addr  = wr_bus.wr_addr;
  assign push_req.data  = wr_bus.wr_data;
  assign wr_bus.wr_ready = ready_q && !full;
  assign push           = wr_bus.wr_valid && wr_bus.wr_ready;
  assign pop            = !empty && (!vga_req || steal);
  assign vga_data       = ram_rdata;
  assign vga_stall      = steal;

  vga_wr_fifo #(.DEPTH(WR_FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_req (push_req),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .level    (fifo_level)
  );

`ifdef VGA_ARB_STARVE_GUARD_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  logic [WAIT_W-1:0] wait_cnt;

  assign steal = vga_req && !empty && (wait_cnt == WAIT_W'(MAX_WAIT));

  // Count cycles the writer is blocked with a full buffer; any drain restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                wait_cnt <= '0;
    else if (pop)            wait_cnt <= '0;
    else if (full && vga_req) wait_cnt <= wait_cnt + 1'b1;
  end
`else
  assign steal = 1'b0;
`endif

  // Writer is held off until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ready_q <= 1'b0;
    else      ready_q <= 1'b1;
  end

  // Fixed-priority port mux: VGA read unless idle or its slot is stolen.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = vga_addr;
    ram_wdata = '0;
    if (pop) begin
      ram_we    = 1'b1;
      ram_addr  = head.addr;
      ram_wdata = head.data;
    end
  end

  // RAM read data arrives one cycle after a granted VGA read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vga_rvalid <= 1'b0;
    else      vga_rvalid <= vga_req && !steal;
  end

endmodule

// File: tb/tb_vga_ram_arbiter.sv
// tb/tb_vga_ram_arbiter.sv - directed and randomized bench for vga_ram_arbiter against a queue-based model
module tb_vga_ram_arbiter;

  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 16;
`ifdef VGA_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        vga_req;
  logic [15:0] vga_addr;
  logic        vga_rvalid;
  logic [7:0]  vga_data;
  logic        vga_stall;
  logic        wr_valid;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic [2:0]  fifo_level;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata;

  vga_ram_arbiter_if wr_bus ();
  assign wr_bus.wr_valid = wr_valid;
  assign wr_bus.wr_addr  = wr_addr;
  assign wr_bus.wr_data  = wr_data;

  vga_ram_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .vga_req    (vga_req),
    .vga_addr   (vga_addr),
    .vga_rvalid (vga_rvalid),
    .vga_data   (vga_data),
    .vga_stall  (vga_stall),
    .wr_bus     (wr_bus),
    .fifo_level (fifo_level),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_rdata  (ram_rdata)
  );

  always #5 clk = ~clk;

  // Image RAM macro stand-in: synchronous, one-cycle read latency.
  logic [7:0] ram_mem [int];
  always @(posedge clk) begin
    if (ram_we) ram_mem[int'(ram_addr)] = ram_wdata;
    ram_rdata <= ram_mem.exists(int'(ram_addr)) ? ram_mem[int'(ram_addr)] : 8'h00;
  end

  // Reference model state
  ent_t       q [$];
  logic [7:0] shadow [int];
  bit         ready_seen;
  bit         prev_read;
  int         prev_addr;
  int         wait_n;

  int checks = 0;
  int errors = 0;

  logic        obs_we, obs_ready, obs_stall, obs_rvalid;
  logic [15:0] obs_addr;
  logic [7:0]  obs_wdata;
  logic [2:0]  obs_level;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: settle, compare outputs to the model, take the edge, advance the model.
  task automatic step();
    int   sz;
    bit   full, steal, we;
    ent_t e;
    #1;
    if (!rst) begin
      q.delete();
      prev_read  = 0;
      wait_n     = 0;
      ready_seen = 0;
    end
    sz    = q.size();
    full  = (sz == DEPTH);
    steal = GUARD && vga_req && sz > 0 && wait_n == MAX_WAIT;
    we    = sz > 0 && (!vga_req || steal);
    obs_we = ram_we; obs_addr = ram_addr; obs_wdata = ram_wdata; obs_ready = wr_bus.wr_ready;
    obs_stall = vga_stall; obs_rvalid = vga_rvalid; obs_level = fifo_level;
    chk("ram_we", 32'(ram_we), 32'(we));
    chk("ram_addr", 32'(ram_addr), we ? 32'(q[0].a) : 32'(vga_addr));
    chk("ram_wdata", 32'(ram_wdata), we ? 32'(q[0].d) : 32'd0);
    chk("wr_ready", 32'(wr_bus.wr_ready), 32'(ready_seen && !full));
    chk("fifo_level", 32'(fifo_level), 32'(sz));
    chk("vga_stall", 32'(vga_stall), 32'(steal));
    chk("vga_rvalid", 32'(vga_rvalid), 32'(prev_read));
    if (prev_read)
      chk("vga_data", 32'(vga_data), shadow.exists(prev_addr) ? 32'(shadow[prev_addr]) : 32'd0);
    @(posedge clk);
    if (rst) begin
      if (we) begin
        shadow[int'(q[0].a)] = q[0].d;
        void'(q.pop_front());
      end
      if (wr_valid && ready_seen && !full) begin
        e.a = wr_addr;
        e.d = wr_data;
        q.push_back(e);
      end
      prev_read = vga_req && !steal;
      prev_addr = int'(vga_addr);
      if (we) wait_n = 0;
      else if (full && vga_req) wait_n++;
      ready_seen = 1;
    end
    @(negedge clk);
  endtask

  initial begin
    int first_we;
    logic stall17, rv18;
    rst = 1'b0; vga_req = 1'b0; vga_addr = '0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    @(negedge clk);

    // Reset state
    step();
    chk("t1_rst_we", 32'(obs_we), 32'd0);
    chk("t1_rst_level", 32'(obs_level), 32'd0);
    chk("t1_rst_rvalid", 32'(obs_rvalid), 32'd0);
    chk("t1_rst_stall", 32'(obs_stall), 32'd0);
    rst = 1'b1;
    step();
    step();
    chk("t1_rel_ready", 32'(obs_ready), 32'd1);
    chk("t1_rel_level", 32'(obs_level), 32'd0);

    // Single write into an idle slot
    wr_valid = 1'b1; wr_addr = 16'h0102; wr_data = 8'hAA;
    step();
    wr_valid = 1'b0;
    step();
    chk("t2_we", 32'(obs_we), 32'd1);
    chk("t2_addr", 32'(obs_addr), 32'h0102);
    chk("t2_wdata", 32'(obs_wdata), 32'hAA);

    // VGA reads back the written pixel
    vga_req = 1'b1; vga_addr = 16'h0102;
    step();
    step();
    chk("t4_rvalid", 32'(obs_rvalid), 32'd1);
    chk("t4_data", 32'(vga_data), 32'hAA);

    // Buffer fills while VGA owns the port, then drains in order
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_addr = 16'(16'h0010 + i); wr_data = 8'(8'h50 + i);
      step();
    end
    wr_valid = 1'b0;
    step();
    chk("t3_full_ready", 32'(obs_ready), 32'd0);
    chk("t3_full_we", 32'(obs_we), 32'd0);
    chk("t3_full_level", 32'(obs_level), 32'd4);
    vga_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_drain_we", 32'(obs_we), 32'd1);
      chk("t3_drain_addr", 32'(obs_addr), 32'(16'h0010 + i));
      chk("t3_drain_data", 32'(obs_wdata), 32'(8'h50 + i));
    end
    step();
    chk("t3_empty_level", 32'(obs_level), 32'd0);

    // Starvation: full buffer with VGA holding the port
    vga_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_addr = 16'(16'h0030 + i); wr_data = 8'(8'h70 + i);
      step();
    end
    wr_valid = 1'b0;
    first_we = 0; stall17 = 1'b0; rv18 = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      step();
      if (obs_we && first_we == 0) first_we = k;
      if (k == 17) stall17 = obs_stall;
      if (k == 18) rv18 = obs_rvalid;
    end
    if (GUARD) begin
      chk("t5_steal_cycle", 32'(first_we), 32'd17);
      chk("t5_stall", 32'(stall17), 32'd1);
      chk("t5_rvalid_after", 32'(rv18), 32'd0);
    end else begin
      chk("t5_steal_cycle", 32'(first_we), 32'd0);
      chk("t5_stall", 32'(stall17), 32'd0);
      chk("t5_rvalid_after", 32'(rv18), 32'd1);
    end
    vga_req = 1'b0;
    repeat (5) step();

    // Reset discards buffered writes
    vga_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_addr = 16'(16'h0040 + i); wr_data = 8'(8'hE0 + i);
      step();
    end
    wr_valid = 1'b0;
    step();
    chk("t6_level3", 32'(obs_level), 32'd3);
    rst = 1'b0;
    step();
    chk("t6_rst_level", 32'(obs_level), 32'd0);
    chk("t6_rst_we", 32'(obs_we), 32'd0);
    rst = 1'b1; vga_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t6_no_write", 32'(obs_we), 32'd0);
    end

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      rst      = ($urandom_range(99) != 0);
      vga_req  = ($urandom_range(9) < 7);
      vga_addr = 16'($urandom_range(31));
      wr_valid = ($urandom_range(1) == 1);
      wr_addr  = 16'($urandom_range(31));
      wr_data  = 8'($urandom_range(255));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
